// File: rtl/inst_sram_ctrl.sv
// -----------------------------------------------------------------------------
// inst_sram_ctrl
//
// Purpose:
//   Instruction-fetch front end for an asynchronous SRAM. It keeps a one-entry
//   instruction buffer:
//     - a fetch whose pc matches the buffered address is served in the same
//       cycle;
//     - a legal fetch that misses starts a fixed-length SRAM read
//       (WAIT_CYCLES wait states) and stalls the pipeline until the buffer
//       is filled;
//     - an illegal fetch (misaligned or outside the 4 MiB window at
//       0x8000_0000) is answered at once with a NOP and an address-error flag.
//
// Parameters:
//   WAIT_CYCLES  : SRAM read wait states per access (1..15)
//
// Ports:
//   clk          in   1   single clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   pc           in  32   fetch address from the PC stage
//   ce           in   1   fetch request from the PC stage
//   inst_o       out 32   fetched instruction (0 = NOP when not a hit)
//   inst_valid_o out  1   inst_o is valid for the current pc
//   stall_req_o  out  1   pipeline stall request
//   addr_err_o   out  1   current pc is misaligned or out of range
//   sram_addr_o  out 20   SRAM word address (registered)
//   sram_data_i  in  32   SRAM read data
//   sram_ce_n_o  out  1   SRAM chip enable, active low (registered)
//   sram_oe_n_o  out  1   SRAM output enable, active low (registered)
//   sram_we_n_o  out  1   SRAM write enable, active low (tied inactive)
//   sram_be_n_o  out  4   SRAM byte enables, active low (all bytes enabled)
// -----------------------------------------------------------------------------
module inst_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stall_req_o,
  output logic        addr_err_o,
  output logic [19:0] sram_addr_o,
  input  logic [31:0] sram_data_i,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [3:0]  sram_be_n_o
);

  // Wait counter load value: READ lasts WAIT_CYCLES cycles (counts down to 0).
  localparam logic [3:0] WCNT_INIT = 4'(WAIT_CYCLES - 32'd1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_wcnt;
  logic        r_buf_valid;
  logic [31:0] r_buf_addr;
  logic [31:0] r_buf_data;

  logic        w_legal;
  logic        w_hit;
  logic        w_idle_hit;

  // Address legality and buffer hit detection.
  always_comb begin
    w_legal    = (pc[31:22] == 10'h200) && (pc[1:0] == 2'b00);
    w_hit      = r_buf_valid && (r_buf_addr == pc);
    w_idle_hit = (r_state == ST_IDLE) && w_hit;
  end

  // Fetch FSM, instruction buffer and registered SRAM control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset also aborts an access in flight: SRAM deselected, nothing kept.
      r_state     <= ST_IDLE;
      r_wcnt      <= 4'd0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= 32'h0000_0000;
      r_buf_data  <= 32'h0000_0000;
      sram_addr_o <= 20'h0_0000;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ce && w_legal && !w_hit) begin
            sram_addr_o <= pc[21:2];
            sram_ce_n_o <= 1'b0;
            sram_oe_n_o <= 1'b0;
            r_wcnt      <= WCNT_INIT;
            r_state     <= ST_READ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          // pc/ce are ignored here; the access always runs to completion.
          if (r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
          end else begin
            r_buf_data  <= sram_data_i;
            // Buffer tag is rebuilt from the latched word address, not from
            // pc, so a pc change during READ cannot corrupt the tag.
            r_buf_addr  <= {10'h200, sram_addr_o, 2'b00};
            r_buf_valid <= 1'b1;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          sram_ce_n_o <= 1'b1;
          sram_oe_n_o <= 1'b1;
        end
      endcase
    end
  end

  // Pipeline-facing outputs; a hit is answered in the same cycle.
  always_comb begin
    stall_req_o  = ce && w_legal && !w_idle_hit;
    inst_valid_o = ce && (w_idle_hit || !w_legal);
    addr_err_o   = ce && !w_legal;
    if (w_idle_hit) begin
      inst_o = r_buf_data;
    end else begin
      inst_o = 32'h0000_0000;
    end
  end

  // Read-only port: no write path.
  assign sram_we_n_o = 1'b1;
  assign sram_be_n_o = 4'b0000;

endmodule

// File: tb/tb_inst_sram_ctrl.sv
module tb_inst_sram_ctrl;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stall_req_o;
  logic        addr_err_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_data_i;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: "busy for N more edges" instead of an FSM.
  bit          m_known = 0;
  bit          m_busy;
  int          m_left;
  logic [19:0] m_saddr;
  bit          m_bv;
  logic [31:0] m_ba;
  logic [31:0] m_bd;

  // Expected outputs for the current cycle.
  logic        e_stall;
  logic        e_valid;
  logic        e_err;
  logic [31:0] e_inst;

  inst_sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .stall_req_o(stall_req_o),
    .addr_err_o(addr_err_o), .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  // Asynchronous SRAM: read data follows the address.
  assign sram_data_i = mem[sram_addr_o[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [31:0] a);
    return (a[31:22] == 10'h200) && (a[1:0] == 2'b00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t pc=%h ce=%b)", name, act, exp, $time, pc, ce);
    end
  endtask

  // Model advances at every rising edge from the inputs held during the cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_known = 1;
      m_busy  = 0;
      m_left  = 0;
      m_saddr = 20'h0;
      m_bv    = 0;
      m_ba    = 32'h0;
      m_bd    = 32'h0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_bv   = 1;
        m_ba   = {10'h200, m_saddr, 2'b00};
        m_bd   = mem[m_saddr[5:0]];
      end
    end else if (ce && is_legal(pc) && !(m_bv && m_ba == pc)) begin
      m_busy  = 1;
      m_left  = W;
      m_saddr = pc[21:2];
    end
  end

  // Drive one cycle's inputs at the falling edge, then compare against the model.
  task automatic drive(input logic r, input logic c, input logic [31:0] p);
    bit hit;
    bit lg;
    @(negedge clk);
    rst = r;
    ce  = c;
    pc  = p;
    #2;
    lg      = is_legal(p);
    hit     = m_bv && !m_busy && (m_ba == p);
    e_stall = c && lg && !hit;
    e_valid = c && (hit || !lg);
    e_err   = c && !lg;
    e_inst  = hit ? m_bd : 32'h0;
    if (m_known) begin
      check("stall", {31'd0, stall_req_o}, {31'd0, e_stall});
      check("valid", {31'd0, inst_valid_o}, {31'd0, e_valid});
      check("addr_err", {31'd0, addr_err_o}, {31'd0, e_err});
      check("inst", inst_o, e_inst);
      check("sram_addr", {12'd0, sram_addr_o}, {12'd0, m_saddr});
      check("sram_ce_n", {31'd0, sram_ce_n_o}, {31'd0, !m_busy});
      check("sram_oe_n", {31'd0, sram_oe_n_o}, {31'd0, !m_busy});
      check("sram_we_n", {31'd0, sram_we_n_o}, 32'd1);
      check("sram_be_n", {28'd0, sram_be_n_o}, 32'd0);
    end
  endtask

  initial begin
    int stalls;
    logic [31:0] p;
    rst = 1'b1;
    ce  = 1'b0;
    pc  = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2408_0001;
    mem[1] = 32'h0000_0000;

    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);

    // Cold miss: first cycle after reset stalls, 3 stall cycles, then hit.
    drive(1'b0, 1'b1, 32'h8000_0000);
    check("cold_stall0", {31'd0, stall_req_o}, 32'd1);
    drive(1'b0, 1'b1, 32'h8000_0000);
    check("cold_stall1", {31'd0, stall_req_o}, 32'd1);
    check("cold_addr", {12'd0, sram_addr_o}, 32'd0);
    check("cold_ce_n", {31'd0, sram_ce_n_o}, 32'd0);
    drive(1'b0, 1'b1, 32'h8000_0000);
    check("cold_stall2", {31'd0, stall_req_o}, 32'd1);
    check("cold_oe_n", {31'd0, sram_oe_n_o}, 32'd0);
    drive(1'b0, 1'b1, 32'h8000_0000);
    check("cold_inst", inst_o, 32'h2408_0001);
    check("cold_valid", {31'd0, inst_valid_o}, 32'd1);
    check("cold_nostall", {31'd0, stall_req_o}, 32'd0);
    check("cold_deselect", {31'd0, sram_ce_n_o}, 32'd1);

    // Sequential fetch to word 1.
    drive(1'b0, 1'b1, 32'h8000_0004);
    check("seq_stall0", {31'd0, stall_req_o}, 32'd1);
    drive(1'b0, 1'b1, 32'h8000_0004);
    check("seq_addr", {12'd0, sram_addr_o}, 32'd1);
    drive(1'b0, 1'b1, 32'h8000_0004);
    check("seq_stall2", {31'd0, stall_req_o}, 32'd1);
    drive(1'b0, 1'b1, 32'h8000_0004);
    check("seq_inst", inst_o, 32'h0000_0000);
    check("seq_valid", {31'd0, inst_valid_o}, 32'd1);

    // Re-fetch hit after an idle cycle.
    drive(1'b0, 1'b0, 32'h8000_0004);
    check("idle_valid", {31'd0, inst_valid_o}, 32'd0);
    drive(1'b0, 1'b1, 32'h8000_0004);
    check("hit_stall", {31'd0, stall_req_o}, 32'd0);
    check("hit_valid", {31'd0, inst_valid_o}, 32'd1);
    check("hit_ce_n", {31'd0, sram_ce_n_o}, 32'd1);

    // Illegal addresses: out of window, then misaligned.
    drive(1'b0, 1'b1, 32'h8040_0000);
    check("oor_err", {31'd0, addr_err_o}, 32'd1);
    check("oor_inst", inst_o, 32'h0);
    check("oor_valid", {31'd0, inst_valid_o}, 32'd1);
    check("oor_stall", {31'd0, stall_req_o}, 32'd0);
    drive(1'b0, 1'b1, 32'h8000_0002);
    check("mis_err", {31'd0, addr_err_o}, 32'd1);
    check("mis_ce_n", {31'd0, sram_ce_n_o}, 32'd1);
    drive(1'b0, 1'b1, 32'h8000_0002);
    check("mis_ce_n2", {31'd0, sram_ce_n_o}, 32'd1);
    check("mis_stall", {31'd0, stall_req_o}, 32'd0);

    // Reset in the second READ cycle aborts; a full fresh miss follows.
    drive(1'b0, 1'b1, 32'h8000_0008);
    drive(1'b0, 1'b1, 32'h8000_0008);
    drive(1'b1, 1'b1, 32'h8000_0008);
    stalls = 0;
    drive(1'b0, 1'b1, 32'h8000_0008);
    check("rst_ce_n", {31'd0, sram_ce_n_o}, 32'd1);
    while (stall_req_o && stalls < 10) begin
      stalls++;
      drive(1'b0, 1'b1, 32'h8000_0008);
    end
    check("rst_stall_cycles", stalls, 32'd3);
    check("rst_refill_inst", inst_o, mem[2]);

    // ce drops during READ: access completes, later fetch of same pc hits.
    drive(1'b0, 1'b1, 32'h8000_000C);
    drive(1'b0, 1'b0, 32'h8000_000C);
    check("cedrop_stall", {31'd0, stall_req_o}, 32'd0);
    drive(1'b0, 1'b0, 32'h8000_000C);
    drive(1'b0, 1'b0, 32'h8000_000C);
    drive(1'b0, 1'b1, 32'h8000_000C);
    check("cedrop_hit_stall", {31'd0, stall_req_o}, 32'd0);
    check("cedrop_hit_inst", inst_o, mem[3]);

    // Randomized traffic, mostly holding pc while stalled.
    p = 32'h8000_0000;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (!(e_stall && sel < 85)) begin
        sel = $urandom_range(0, 99);
        if (sel < 70)      p = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
        else if (sel < 85) p = 32'h8000_0000 | 32'($urandom_range(1, 3)) | (32'($urandom_range(0, 15)) << 2);
        else               p = $urandom;
      end
      drive(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
